// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: data width, opcodes, FSM encodings.
package alu_arbiter_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request/response channel pair into the ALU arbiter.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int DW = DATA_W
);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU; no carry or borrow is produced.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DW = DATA_W
)(
    input  logic [2:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_result
);

    logic [7:0] w_mul;

    // 4x4 multiply on the low nibbles always fits in 8 bits
    assign w_mul = {4'b0000, i_a[3:0]} * {4'b0000, i_b[3:0]};

    // opcode decode
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_NOT:  o_result = ~i_a;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_MUL:  o_result = DW'(w_mul);
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters, one transaction at a time.
//   state   | meaning
//   ST_IDLE | grant offered to a requester, operands captured on handshake
//   ST_EXEC | ALU evaluates captured operands, result registered
//   ST_RESP | result presented to owner until it takes it
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DW        = DATA_W,
    parameter int PRIO_MODE = 0
)(
    input  logic          i_clk,
    input  logic          i_rst,
    alu_arbiter_if.slave  p_req0,
    alu_arbiter_if.slave  p_req1,
    output logic          o_busy,
    output logic          o_owner
);

    logic [1:0]    r_state;
    logic          r_last_grant;
    logic          r_owner;
    logic [2:0]    r_op;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_result;
    logic          r_zero;

    logic          w_idle;
    logic          w_any;
    logic          w_grant;
    logic          w_rsp_take;
    logic [DW-1:0] w_alu_result;

    assign w_idle = (r_state == ST_IDLE);
    assign w_any  = p_req0.req_valid | p_req1.req_valid;

    // grant selection: lone requester wins, ties go by mode
    always_comb begin
        w_grant = 1'b0;
        if (p_req0.req_valid && p_req1.req_valid) begin
            w_grant = (PRIO_MODE != 0) ? 1'b0 : ~r_last_grant;
        end else begin
            w_grant = p_req1.req_valid;
        end
    end

    assign p_req0.req_ready = w_idle && w_any && !w_grant;
    assign p_req1.req_ready = w_idle && w_any &&  w_grant;

    assign p_req0.rsp_valid = (r_state == ST_RESP) && !r_owner;
    assign p_req1.rsp_valid = (r_state == ST_RESP) &&  r_owner;
    assign p_req0.rsp_data  = r_result;
    assign p_req1.rsp_data  = r_result;
    assign p_req0.rsp_zero  = r_zero;
    assign p_req1.rsp_zero  = r_zero;

    assign w_rsp_take = r_owner ? p_req1.rsp_ready : p_req0.rsp_ready;

    assign o_busy  = !w_idle;
    assign o_owner = r_owner;

    alu_arbiter_alu #(.DW(DW)) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result)
    );

    // transaction FSM: accept, execute, respond
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= OP_NOP;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_op         <= w_grant ? p_req1.req_op : p_req0.req_op;
                        r_a          <= w_grant ? p_req1.req_a  : p_req0.req_a;
                        r_b          <= w_grant ? p_req1.req_b  : p_req0.req_b;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= w_alu_result;
                    r_zero   <= (w_alu_result == '0);
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_take) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances share one
// stimulus; a transaction-level model predicts grants, results and timing.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       v   [2];
    logic [2:0] op  [2];
    logic [7:0] a   [2];
    logic [7:0] b   [2];
    logic       rr  [2];

    logic       obs_rdy  [2];
    logic       obs_rv   [2];
    logic       obs_zero [2];
    logic [7:0] obs_data [2];
    logic       obs_busy, obs_owner;
    logic       busy_rr, owner_rr, busy_fp, owner_fp;

    int         n_checks = 0;
    int         n_errors = 0;

    bit         m_infl;
    int         m_age, m_own, m_last;
    logic [7:0] m_data;
    logic       m_zero;
    bit         hs [2];
    bit         rd [2];
    logic [7:0] last_data [2];
    logic       last_zero [2];
    int         grant_log [$];
    int         lat;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DW(8)) if_rr0 ();
    alu_arbiter_if #(.DW(8)) if_rr1 ();
    alu_arbiter_if #(.DW(8)) if_fp0 ();
    alu_arbiter_if #(.DW(8)) if_fp1 ();

    assign if_rr0.req_valid = v[0];  assign if_rr0.req_op = op[0];  assign if_rr0.req_a = a[0];
    assign if_rr0.req_b     = b[0];  assign if_rr0.rsp_ready = rr[0];
    assign if_rr1.req_valid = v[1];  assign if_rr1.req_op = op[1];  assign if_rr1.req_a = a[1];
    assign if_rr1.req_b     = b[1];  assign if_rr1.rsp_ready = rr[1];
    assign if_fp0.req_valid = v[0];  assign if_fp0.req_op = op[0];  assign if_fp0.req_a = a[0];
    assign if_fp0.req_b     = b[0];  assign if_fp0.rsp_ready = rr[0];
    assign if_fp1.req_valid = v[1];  assign if_fp1.req_op = op[1];  assign if_fp1.req_a = a[1];
    assign if_fp1.req_b     = b[1];  assign if_fp1.rsp_ready = rr[1];

    alu_arbiter #(.DW(8), .PRIO_MODE(0)) dut_rr (
        .i_clk(clk), .i_rst(rst), .p_req0(if_rr0), .p_req1(if_rr1),
        .o_busy(busy_rr), .o_owner(owner_rr)
    );

    alu_arbiter #(.DW(8), .PRIO_MODE(1)) dut_fp (
        .i_clk(clk), .i_rst(rst), .p_req0(if_fp0), .p_req1(if_fp1),
        .o_busy(busy_fp), .o_owner(owner_fp)
    );

    always_comb begin
        obs_rdy[0]  = sel ? if_fp0.req_ready : if_rr0.req_ready;
        obs_rdy[1]  = sel ? if_fp1.req_ready : if_rr1.req_ready;
        obs_rv[0]   = sel ? if_fp0.rsp_valid : if_rr0.rsp_valid;
        obs_rv[1]   = sel ? if_fp1.rsp_valid : if_rr1.rsp_valid;
        obs_data[0] = sel ? if_fp0.rsp_data  : if_rr0.rsp_data;
        obs_data[1] = sel ? if_fp1.rsp_data  : if_rr1.rsp_data;
        obs_zero[0] = sel ? if_fp0.rsp_zero  : if_rr0.rsp_zero;
        obs_zero[1] = sel ? if_fp1.rsp_zero  : if_rr1.rsp_zero;
        obs_busy    = sel ? busy_fp  : busy_rr;
        obs_owner   = sel ? owner_fp : owner_rr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_alu(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int xa, yb, r;
        xa = int'(x);
        yb = int'(y);
        case (o)
            3'd0:    r = 255 - xa;
            3'd1:    r = xa | yb;
            3'd2:    r = xa ^ yb;
            3'd3:    r = xa & yb;
            3'd4:    r = (xa % 16) * (yb % 16);
            3'd5:    r = (xa + yb) % 256;
            3'd6:    r = (xa - yb + 256) % 256;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    // One clock: check outputs mid-cycle against the model, advance the model, step past the edge.
    task automatic cyc();
        int g;
        @(negedge clk);
        hs[0] = 0; hs[1] = 0; rd[0] = 0; rd[1] = 0;
        chk("busy", obs_busy, m_infl);
        if (!m_infl) begin
            g = -1;
            if (v[0] && v[1]) g = sel ? 0 : 1 - m_last;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
            chk("ready0", obs_rdy[0], g == 0);
            chk("ready1", obs_rdy[1], g == 1);
            chk("rsp_valid0_idle", obs_rv[0], 0);
            chk("rsp_valid1_idle", obs_rv[1], 0);
            if (!rst && g >= 0) begin
                hs[g]  = 1;
                m_infl = 1;
                m_age  = 0;
                m_own  = g;
                m_last = g;
                m_data = ref_alu(op[g], a[g], b[g]);
                m_zero = (m_data == 8'd0);
                grant_log.push_back(g);
            end
        end else begin
            chk("ready0_busy", obs_rdy[0], 0);
            chk("ready1_busy", obs_rdy[1], 0);
            chk("owner", obs_owner, m_own);
            if (m_age == 0) begin
                chk("rsp_valid0_exec", obs_rv[0], 0);
                chk("rsp_valid1_exec", obs_rv[1], 0);
                m_age = 1;
            end else begin
                chk("rsp_valid_owner", obs_rv[m_own], 1);
                chk("rsp_valid_other", obs_rv[1 - m_own], 0);
                chk("rsp_data", obs_data[m_own], m_data);
                chk("rsp_zero", obs_zero[m_own], m_zero);
                if (rr[m_own] && !rst) begin
                    rd[m_own]        = 1;
                    last_data[m_own] = obs_data[m_own];
                    last_zero[m_own] = obs_zero[m_own];
                    m_infl           = 0;
                end
            end
        end
        if (rst) begin
            m_infl = 0;
            m_last = 1;
            m_age  = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic mode);
        v[0] = 0; v[1] = 0; rr[0] = 0; rr[1] = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        sel    = mode;
        m_infl = 0;
        m_last = 1;
        m_age  = 0;
        cyc();
        rst = 0;
        chk("reset_owner", obs_owner, 0);
        chk("reset_busy", obs_busy, 0);
    endtask

    task automatic wait_hs(input int n);
        bit got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            cyc();
            got = hs[n];
        end
        chk("grant_timeout", got, 1);
    endtask

    task automatic send(input int n, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        v[n] = 1; op[n] = o; a[n] = x; b[n] = y;
        wait_hs(n);
        v[n] = 0;
    endtask

    task automatic collect(input int n, input int stall, output int cycles);
        bit got = 0;
        rr[n] = 0;
        cycles = 0;
        repeat (stall) begin
            cyc();
            cycles++;
        end
        rr[n] = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc();
            cycles++;
            got = rd[n];
        end
        rr[n] = 0;
        chk("rsp_timeout", got, 1);
    endtask

    task automatic drain();
        v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
        for (int i = 0; i < 6; i++) cyc();
        rr[0] = 0; rr[1] = 0;
        chk("drained", m_infl, 0);
    endtask

    task automatic rand_run(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            cyc();
            for (int n = 0; n < 2; n++) begin
                if (hs[n] || !v[n]) begin
                    v[n]  = ($urandom_range(0, 2) != 0);
                    op[n] = 3'($urandom_range(0, 7));
                    a[n]  = 8'($urandom);
                    b[n]  = ($urandom_range(0, 3) == 0) ? a[n] : 8'($urandom);
                end
                rr[n] = 1'($urandom_range(0, 1));
            end
        end
        drain();
    endtask

    initial begin
        v[0] = 0; v[1] = 0; rr[0] = 0; rr[1] = 0;
        op[0] = 0; op[1] = 0; a[0] = 0; a[1] = 0; b[0] = 0; b[1] = 0;
        sel = 0; rst = 1;
        m_infl = 0; m_last = 1; m_age = 0; m_own = 0;

        // reset, then a single ADD from req0
        do_reset(1'b0);
        send(0, 3'b101, 8'hF0, 8'h20);
        collect(0, 0, lat);
        chk("t1_latency", lat, 2);
        chk("t1_data", last_data[0], 8'h10);
        chk("t1_zero", last_zero[0], 0);

        // multiply and subtract-to-zero
        send(0, 3'b100, 8'hFF, 8'hF3);
        collect(0, 0, lat);
        chk("t3_mul", last_data[0], 8'h2D);
        send(1, 3'b110, 8'h05, 8'h05);
        collect(1, 0, lat);
        chk("t3_sub_data", last_data[1], 8'h00);
        chk("t3_sub_zero", last_zero[1], 1);
        send(0, 3'b111, 8'h12, 8'h34);
        collect(0, 0, lat);
        chk("t3_nop_zero", last_zero[0], 1);

        // round-robin with both requesters permanently valid
        do_reset(1'b0);
        grant_log.delete();
        v[0] = 1; op[0] = 3'b001; a[0] = 8'h0F; b[0] = 8'hF0;
        v[1] = 1; op[1] = 3'b010; a[1] = 8'hAA; b[1] = 8'h55;
        rr[0] = 1; rr[1] = 1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            for (int n = 0; n < 2; n++) if (hs[n]) begin
                op[n] = 3'($urandom_range(0, 7)); a[n] = 8'($urandom); b[n] = 8'($urandom);
            end
        end
        chk("t2_count", grant_log.size() >= 4, 1);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("t2_grant", grant_log[k], k % 2);
        drain();

        // req1 response stalled while req0 waits
        send(1, 3'b011, 8'h3C, 8'h0F);
        v[0] = 1; op[0] = 3'b000; a[0] = 8'h5A; b[0] = 8'h00;
        collect(1, 6, lat);
        chk("t4_data", last_data[1], 8'h0C);
        wait_hs(0);
        v[0] = 0;
        collect(0, 0, lat);
        chk("t4_req0_data", last_data[0], 8'hA5);

        // reset during EXEC drops the transaction
        send(0, 3'b101, 8'h01, 8'h02);
        rst = 1;
        cyc();
        rst = 0;
        rr[0] = 1; rr[1] = 1;
        cyc();
        chk("t5_busy", obs_busy, 0);
        chk("t5_no_rsp", obs_rv[0], 0);
        cyc();
        rr[0] = 0; rr[1] = 0;
        send(0, 3'b101, 8'h01, 8'h02);
        collect(0, 1, lat);
        chk("t5_reissue", last_data[0], 8'h03);

        rand_run(300);

        // fixed priority: req1 starves while req0 stays valid
        do_reset(1'b1);
        grant_log.delete();
        v[0] = 1; op[0] = 3'b101; a[0] = 8'h11; b[0] = 8'h22;
        v[1] = 1; op[1] = 3'b001; a[1] = 8'h33; b[1] = 8'h44;
        rr[0] = 1; rr[1] = 1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (hs[0]) begin
                op[0] = 3'($urandom_range(0, 7)); a[0] = 8'($urandom); b[0] = 8'($urandom);
            end
        end
        chk("t6_count", grant_log.size() >= 8, 1);
        for (int k = 0; k < grant_log.size(); k++) chk("t6_grant", grant_log[k], 0);
        drain();

        rand_run(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
